// File: rtl/mem_pkg.sv
// Shared constants and types for the dual-port pipelined memory.
// Read-during-write selectors and the clear sweep state type.
package mem_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

endpackage

// File: rtl/mem_rd_pipe.sv
// READ_LATENCY-deep delay line for read data and its valid flag.
// The last stage only updates on valid, so the output word holds between reads.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] stage_data [LATENCY];
    logic [LATENCY-1:0]    stage_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            stage_valid[0] <= in_valid;
            if (in_valid) begin
                stage_data[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    assign out_valid = stage_valid[LATENCY-1];
    assign out_data  = stage_data[LATENCY-1];

endmodule

// File: rtl/mem_dp_pipe.sv
// Byte-strobed simple dual-port memory with a pipelined read path
// and a one-entry-per-cycle clear sweep that locks out both ports while busy.
module mem_dp_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int MEM_SIZE     = 64,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    input  logic                    clear_start,
    output logic                    busy,
    output logic                    clear_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    clear_state_e          state, state_next;
    logic [ADDR_WIDTH-1:0] clear_addr, clear_addr_next;
    logic                  done_next;

    logic                  wr_hit;
    logic                  rd_accept;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    assign busy        = (state == CLEAR);
    assign wr_hit      = write_en && !busy && ({1'b0, write_address} < MEM_LIMIT);
    assign rd_accept   = read_en && !busy;
    assign rd_in_range = ({1'b0, read_address} < MEM_LIMIT);

    // The merged word serves both the array update and the new-data bypass.
    always_comb begin
        wr_merged = mem[write_address];
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (write_strobe[b]) begin
                wr_merged[b*8 +: 8] = data_in[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE == RDW_NEW && wr_hit && write_address == read_address) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[read_address];
            end
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_addr] <= '0;
        end else if (wr_hit) begin
            mem[write_address] <= wr_merged;
        end
    end

    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        done_next       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next      = CLEAR;
                    clear_addr_next = '0;
                end
            end
            CLEAR: begin
                clear_addr_next = clear_addr + 1'b1;
                if (clear_addr == LAST_ADDR) begin
                    state_next      = IDLE;
                    clear_addr_next = '0;
                    done_next       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clear_addr <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
            clear_done <= done_next;
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (read_valid),
        .out_data  (data_out)
    );

endmodule

// File: tb/tb_mem_dp_pipe.sv
// Bench for mem_dp_pipe: two instances (latency 1/old-data/64 entries and
// latency 3/new-data/48 entries) driven in lockstep against a behavioural model.
module tb_mem_dp_pipe;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_en = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    write_strobe = '0;
    logic          read_en = 1'b0;
    logic [AW-1:0] read_address = '0;
    logic          clear_start = 1'b0;

    logic [DW-1:0] data_out_a, data_out_b;
    logic          read_valid_a, read_valid_b;
    logic          busy_a, busy_b;
    logic          clear_done_a, clear_done_b;

    always #5 clk = ~clk;

    mem_dp_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(64), .READ_LATENCY(1), .RDW_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .write_strobe(write_strobe), .read_en(read_en),
        .read_address(read_address), .data_out(data_out_a), .read_valid(read_valid_a),
        .clear_start(clear_start), .busy(busy_a), .clear_done(clear_done_a)
    );

    mem_dp_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(48), .READ_LATENCY(3), .RDW_MODE(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .write_strobe(write_strobe), .read_en(read_en),
        .read_address(read_address), .data_out(data_out_b), .read_valid(read_valid_b),
        .clear_start(clear_start), .busy(busy_b), .clear_done(clear_done_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: per-instance word array plus a list of reads waiting to emerge.
    int msize [2] = '{64, 48};
    int lat   [2] = '{1, 3};
    int rdw   [2] = '{0, 1};

    logic [DW-1:0] mdl_mem  [2][64];
    bit            mdl_busy [2];
    int            mdl_clr  [2];
    bit            mdl_done [2];
    bit            mdl_valid[2];
    logic [DW-1:0] mdl_last [2];

    typedef struct {
        int            inst;
        int            due;
        logic [DW-1:0] data;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] init;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    logic [DW-1:0] fill_data [64];

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] din, logic [3:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            mdl_busy[i]  = 1'b0;
            mdl_clr[i]   = 0;
            mdl_done[i]  = 1'b0;
            mdl_valid[i] = 1'b0;
            mdl_last[i]  = '0;
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] word;
        int wa, ra;
        cyc++;
        for (int i = 0; i < 2; i++) mdl_done[i] = 1'b0;
        if (!rst_n) return;
        wa = int'(write_address);
        ra = int'(read_address);
        for (int i = 0; i < 2; i++) begin
            if (!mdl_busy[i] && read_en) begin
                word = (ra < msize[i]) ? mdl_mem[i][ra] : '0;
                if (rdw[i] == 1 && write_en && wa == ra && ra < msize[i])
                    word = merge(word, data_in, write_strobe);
                pend.push_back('{i, cyc + lat[i] - 1, word});
            end
            if (mdl_busy[i]) begin
                mdl_mem[i][mdl_clr[i]] = '0;
                mdl_clr[i]++;
                if (mdl_clr[i] == msize[i]) begin
                    mdl_busy[i] = 1'b0;
                    mdl_done[i] = 1'b1;
                end
            end else begin
                if (write_en && wa < msize[i])
                    mdl_mem[i][wa] = merge(mdl_mem[i][wa], data_in, write_strobe);
                if (clear_start) begin
                    mdl_busy[i] = 1'b1;
                    mdl_clr[i]  = 0;
                end
            end
        end
        mdl_valid[0] = 1'b0;
        mdl_valid[1] = 1'b0;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == cyc) begin
                mdl_valid[pend[k].inst] = 1'b1;
                mdl_last[pend[k].inst]  = pend[k].data;
                pend.delete(k);
            end
        end
    endtask

    task automatic check_output();
        check("valid_a", {31'b0, read_valid_a}, {31'b0, mdl_valid[0]});
        check("data_a",  data_out_a, mdl_last[0]);
        check("busy_a",  {31'b0, busy_a}, {31'b0, mdl_busy[0]});
        check("done_a",  {31'b0, clear_done_a}, {31'b0, mdl_done[0]});
        check("valid_b", {31'b0, read_valid_b}, {31'b0, mdl_valid[1]});
        check("data_b",  data_out_b, mdl_last[1]);
        check("busy_b",  {31'b0, busy_b}, {31'b0, mdl_busy[1]});
        check("done_b",  {31'b0, clear_done_b}, {31'b0, mdl_done[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                                  input logic [3:0] strb, input logic re, input logic [AW-1:0] ra,
                                  input logic cs);
        write_en      = we;
        write_address = wa;
        data_in       = din;
        write_strobe  = strb;
        read_en       = re;
        read_address  = ra;
        clear_start   = cs;
        tick();
    endtask

    task automatic idle();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && (busy_a || busy_b); n++) idle();
        check("idle_wait", {31'b0, busy_a | busy_b}, '0);
    endtask

    task automatic wait_valid_b();
        for (int n = 0; n < 6 && !read_valid_b; n++) idle();
        check("valid_b_wait", {31'b0, read_valid_b}, 32'd1);
    endtask

    task automatic fill_all();
        for (int a = 0; a < 64; a++) begin
            fill_data[a] = $urandom;
            apply_stimulus(1'b1, AW'(a), fill_data[a], 4'hF, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] vb_hist;
        int busy_cnt, done_cnt, nonzero;

        vecs[0] = '{6'd0,  32'h0000_0000, 32'h1122_3344, 4'hF, 32'h1122_3344, 32'h1122_3344};
        vecs[1] = '{6'd1,  32'hAAAA_AAAA, 32'h0000_00A5, 4'h1, 32'hAAAA_AAA5, 32'hAAAA_AAA5};
        vecs[2] = '{6'd5,  32'h1234_5678, 32'hDEAD_BEEF, 4'hA, 32'hDE34_BE78, 32'hDE34_BE78};
        vecs[3] = '{6'd50, 32'hFFFF_FFFF, 32'h0000_0000, 4'h6, 32'hFF00_00FF, 32'h0000_0000};
        vecs[4] = '{6'd7,  32'h0000_0000, 32'hCAFE_F00D, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{6'd47, 32'h0102_0304, 32'hF0E0_D0C0, 4'h8, 32'hF002_0304, 32'hF002_0304};

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) mdl_mem[i][a] = 'x;
        model_reset();
        #2;
        check_output();
        #10 rst_n = 1'b1;

        fill_all();
        idle();

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(1'b1, vecs[v].addr, vecs[v].init, 4'hF, 1'b0, '0, 1'b0);
            apply_stimulus(1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 1'b0, '0, 1'b0);
            apply_stimulus(1'b0, '0, '0, '0, 1'b1, vecs[v].addr, 1'b0);
            check("tbl_valid_a", {31'b0, read_valid_a}, 32'd1);
            check("tbl_data_a", data_out_a, vecs[v].exp_a);
            wait_valid_b();
            check("tbl_data_b", data_out_b, vecs[v].exp_b);
        end

        // Same-edge read and write of address 2.
        apply_stimulus(1'b1, 6'd2, 32'h0000_0022, 4'hF, 1'b0, '0, 1'b0);
        apply_stimulus(1'b1, 6'd2, 32'h0000_00A5, 4'hF, 1'b1, 6'd2, 1'b0);
        check("rdw_old_a", data_out_a, 32'h0000_0022);
        wait_valid_b();
        check("rdw_new_b", data_out_b, 32'h0000_00A5);
        idle();

        // Back-to-back reads through the three-stage pipe.
        vb_hist = '0;
        for (int t = 0; t < 8; t++) begin
            apply_stimulus(1'b0, '0, '0, '0, (t < 4), AW'(t), 1'b0);
            vb_hist[t] = read_valid_b;
        end
        check("b2b_pattern_b", {24'b0, vb_hist}, 32'h0000_003C);

        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                           1'($urandom), AW'($urandom), ($urandom_range(0, 79) == 0));
        end

        wait_idle();
        fill_all();
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 0; t < 80; t++) begin
            if (t == 0)
                apply_stimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
            else if (t < 64)
                apply_stimulus(1'($urandom), AW'($urandom), $urandom, 4'hF,
                               1'($urandom), AW'($urandom), 1'($urandom));
            else
                idle();
            busy_cnt += int'(busy_a);
            done_cnt += int'(clear_done_a);
        end
        check("clear_busy_cycles", busy_cnt, 32'd64);
        check("clear_done_pulses", done_cnt, 32'd1);
        wait_idle();
        nonzero = 0;
        for (int a = 0; a < 64; a++) begin
            apply_stimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
            if (read_valid_a && data_out_a != '0) nonzero++;
        end
        check("clear_all_zero", nonzero, 32'd0);
        for (int t = 0; t < 4; t++) idle();

        // Abort a sweep after ten entries have been zeroed.
        fill_all();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        for (int t = 0; t < 10; t++) idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        idle();
        #2 rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            apply_stimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
            check("abort_data_a", data_out_a, (a < 10) ? 32'h0 : fill_data[a]);
        end
        for (int t = 0; t < 4; t++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
